reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-port register file for the pipelined core.
- Provides NR combinational read ports and two write ports, with a hardwired zero register and a configurable stack-pointer reset value.
- Holds a per-register pending scoreboard that hazard logic uses to stall on in-flight writes.
- Sits between decode (read and issue) and writeback (write and clear), and replaces the single-write-port register file.

## Interface
- DW, 32, data width in bits
- AW, 5, address width; depth = 2**AW entries
- NR, 3, number of read ports (NR ≥ 1)
- SP_IDX, 29, index of register loaded with SP_INIT on reset
- SP_INIT, 32'h3c, reset value of register SP_IDX
- DBG_IDX, 16, index mirrored on dbg_q
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- we0  in  1  write enable, port 0
- wa0  in  AW  write address, port 0
- wd0  in  DW  write data, port 0
- we1  in  1  write enable, port 1; has priority over port 0
- wa1  in  AW  write address, port 1
- wd1  in  DW  write data, port 1
- ra  in  NR*AW  flattened read addresses; port i uses bits [i*AW +: AW]
- rd  out  NR*DW  flattened read data; port i uses bits [i*DW +: DW]
- rd_pend  out  NR  pending flag for each read address
- iss_en  in  1  issue: mark destination register pending
- iss_addr  in  AW  issue destination address
- flush  in  1  synchronously clear all pending bits
- dbg_q  out  DW  content of register DBG_IDX

## Operation
- **Storage:** 2**AW × DW registers. Index 0 reads 0 and has rd_pend=0 on every port. Writes and issues to index 0 are ignored.
- **Write:** on a rising edge with weN=1 and waN≠0, rf[waN] ← wdN.
  - If we0 and we1 are both set and wa0==wa1, wd1 is stored.
  - If the addresses differ, both writes complete in the same cycle.
- **Scoreboard:** one pending bit per entry.
  - An edge with iss_en=1 and iss_addr≠0 sets pend[iss_addr].
  - An edge with weN=1 clears pend[waN].
  - If issue and a write hit the same address on the same edge, the bit ends set; issue wins, because a newer producer is in flight.
  - flush clears all bits. If iss_en is asserted on the same edge as flush, its bit ends set.
- **Reads:** combinational. rd[i]=rf[ra_i] and rd_pend[i]=pend[ra_i], subject to the bypass configuration below.
- **Debug:** dbg_q=rf[DBG_IDX], taken from storage with no bypass.
- **Reset (rst_n=0, asynchronous):**
  - Every rf entry is set to 0 except rf[SP_IDX]=SP_INIT.
  - All pending bits are set to 0.
  - Resulting outputs: rd=stored values, rd_pend=0, dbg_q=rf[DBG_IDX] (0 unless DBG_IDX==SP_IDX).
  - Reset asserted mid-write discards the write.
- **Width handling:** wd and rd are exactly DW bits; there is no sign or zero extension. Addresses are used in full; there is no wrap logic, since depth is exactly 2**AW.

## Timing
- Write-to-read latency is 1 edge without bypass. With bypass it is 0, combinational in the same cycle.
- Issue-to-pend latency is 1 edge: rd_pend rises in the cycle after iss_en.
- Write-to-pend-clear latency is 1 edge. With bypass, rd_pend reads 0 in the same cycle as the write.
- Release of rst_n takes effect from the next rising edge; there is no synchronizer inside the block.
- Every read port sees identical behaviour. All ports may address the same register simultaneously.

## Configuration
- **REG_FILE_BYPASS_EN defined:** when weN=1 and waN==ra_i≠0, rd[i] returns wdN and rd_pend[i]=0 in the same cycle.
  - If both write ports match the read address, wd1 is returned.
  - If iss_en also targets the same address in that cycle, rd_pend[i] is still 0; the new pending bit shows from the next cycle.
- **REG_FILE_BYPASS_EN undefined:** reads always return stored state and the pending bit; written data is visible one cycle later.

## Test plan
- **Reset:** assert rst_n=0 mid-cycle, with ra = {29,0,16}. Require rd = {0x3c,0,0} immediately (asynchronous) and rd_pend=0.
- **Dual write:** we0 (wa0=5, wd0=0x11) and we1 (wa1=5, wd1=0x22) on the same edge. The next cycle must read rf[5]=0x22. Repeat with wa1=6: rf[5]=0x11 and rf[6]=0x22.
- **Zero register:** write 0xFFFF_FFFF to address 0 and issue to address 0. Require rd=0 and rd_pend=0 on all ports.
- **Scoreboard:**
  - Issue r7, then rd_pend=1 on the next cycle.
  - Write r7 with iss_en=1 on r7 on the same edge, then pend stays 1.
  - Write r7 alone, then pend=0.
  - flush with iss_en on r8: only r8 is pending.
- **Bypass:** with REG_FILE_BYPASS_EN, we0 writes r3=0xABCD while ra0=3. Require rd0=0xABCD and rd_pend0=0 in the same cycle. Without the macro, require the old value in that cycle and 0xABCD on the next.
- **Debug mirror:** write r16=0x1234. dbg_q=0x1234 after the edge, and stays unchanged in the write cycle even with bypass enabled.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: write/read/issue/debug bus between decode-writeback and reg_file_mp
// master: we0/wa0/wd0, we1/wa1/wd1, ra, iss_en/iss_addr, flush out; rd, rd_pend, dbg_q in
// slave:  mirror image of master
interface reg_file_mp_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 3
);
  logic           we0;
  logic [AW-1:0]  wa0;
  logic [DW-1:0]  wd0;
  logic           we1;
  logic [AW-1:0]  wa1;
  logic [DW-1:0]  wd1;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]  rd_pend;
  logic           iss_en;
  logic [AW-1:0]  iss_addr;
  logic           flush;
  logic [DW-1:0]  dbg_q;
  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra, iss_en, iss_addr, flush,
    input  rd, rd_pend, dbg_q
  );
  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra, iss_en, iss_addr, flush,
    output rd, rd_pend, dbg_q
  );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: NR-read / 2-write register file with zero register, SP reset value and pending scoreboard
// ports: clk, rst_n (async active-low), bus (reg_file_mp_if.slave: writes, reads, issue/flush, dbg_q)
// optional: define REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding
module reg_file_mp #(
  parameter int            DW      = 32,
  parameter int            AW      = 5,
  parameter int            NR      = 3,
  parameter int            SP_IDX  = 29,
  parameter logic [DW-1:0] SP_INIT = 32'h3c,
  parameter int            DBG_IDX = 16
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_mp_if.slave bus
);
  localparam int N = 1 << AW;
  logic [DW-1:0] rf [N];
  logic [N-1:0]  pend, pend_d;
  logic [AW-1:0] a [NR];
`ifdef REG_FILE_BYPASS_EN
  logic h0, h1;
`endif
  // port 1 is written last so it wins a same-address collision
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) rf[i] <= (i == SP_IDX) ? SP_INIT : '0;
    end else begin
      if (bus.we0 && bus.wa0 != '0) rf[bus.wa0] <= bus.wd0;
      if (bus.we1 && bus.wa1 != '0) rf[bus.wa1] <= bus.wd1;
    end
  // issue is applied after clears so a newer in-flight producer keeps the bit set
  always_comb begin
    pend_d = bus.flush ? '0 : pend;
    if (bus.we0) pend_d[bus.wa0] = 1'b0;
    if (bus.we1) pend_d[bus.wa1] = 1'b0;
    if (bus.iss_en) pend_d[bus.iss_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= '0;
    else pend <= pend_d;
  always_comb begin
    bus.rd = '0;
    bus.rd_pend = '0;
`ifdef REG_FILE_BYPASS_EN
    h0 = 1'b0;
    h1 = 1'b0;
`endif
    for (int i = 0; i < NR; i++) begin
      a[i] = bus.ra[i*AW +: AW];
`ifdef REG_FILE_BYPASS_EN
      h0 = bus.we0 && bus.wa0 == a[i];
      h1 = bus.we1 && bus.wa1 == a[i];
      bus.rd[i*DW +: DW] = a[i] == '0 ? '0 : h1 ? bus.wd1 : h0 ? bus.wd0 : rf[a[i]];
      bus.rd_pend[i] = a[i] != '0 && !h0 && !h1 && pend[a[i]];
`else
      bus.rd[i*DW +: DW] = a[i] == '0 ? '0 : rf[a[i]];
      bus.rd_pend[i] = a[i] != '0 && pend[a[i]];
`endif
    end
  end
  assign bus.dbg_q = rf[DBG_IDX];
endmodule
